// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Brief    : Two-master round-robin bus arbiter with master-to-slave mux.
//            Optional grant preemption when BUS_ARB_PREEMPT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             breq0_,
    input  logic             breq1_,
    output logic             bgrt0_,
    output logic             bgrt1_,
    input  logic [WIDTH-1:0] m0_adr,
    input  logic [WIDTH-1:0] m1_adr,
    input  logic [WIDTH-1:0] m0_wdata,
    input  logic [WIDTH-1:0] m1_wdata,
    input  logic             m0_memwrite,
    input  logic             m1_memwrite,
    output logic [WIDTH-1:0] s_adr,
    output logic [WIDTH-1:0] s_wdata,
    output logic             s_memwrite,
    output logic             busy,
    output logic             owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   w_preempt;

`ifdef BUS_ARB_PREEMPT_EN
    localparam int              c_HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(MAX_HOLD - 1);

    logic [c_HW-1:0] r_hold;

    // Counter saturates at the last allowed cycle; preemption fires only once the
    // other master is actually waiting.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_hold <= '0;
        end else if (w_state_nxt != r_state) begin
            r_hold <= '0;
        end else if (r_state != S_IDLE && r_hold != c_HOLD_LAST) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    assign w_preempt = (r_hold == c_HOLD_LAST);
`else
    assign w_preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == S_GNT0) begin
                r_last <= 1'b0;
            end else if (w_state_nxt == S_GNT1) begin
                r_last <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!breq0_ && !breq1_) begin
                    w_state_nxt = r_last ? S_GNT0 : S_GNT1;
                end else if (!breq0_) begin
                    w_state_nxt = S_GNT0;
                end else if (!breq1_) begin
                    w_state_nxt = S_GNT1;
                end
            end
            S_GNT0: begin
                if (breq0_) begin
                    w_state_nxt = !breq1_ ? S_GNT1 : S_IDLE;
                end else if (w_preempt && !breq1_) begin
                    w_state_nxt = S_GNT1;
                end
            end
            S_GNT1: begin
                if (breq1_) begin
                    w_state_nxt = !breq0_ ? S_GNT0 : S_IDLE;
                end else if (w_preempt && !breq0_) begin
                    w_state_nxt = S_GNT0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_adr      = '0;
        s_wdata    = '0;
        s_memwrite = 1'b0;
        case (r_state)
            S_GNT0: begin
                s_adr      = m0_adr;
                s_wdata    = m0_wdata;
                s_memwrite = m0_memwrite;
            end
            S_GNT1: begin
                s_adr      = m1_adr;
                s_wdata    = m1_wdata;
                s_memwrite = m1_memwrite;
            end
            default: ;
        endcase
    end

    assign bgrt0_ = (r_state != S_GNT0);
    assign bgrt1_ = (r_state != S_GNT1);
    assign busy   = (r_state == S_GNT0) || (r_state == S_GNT1);
    assign owner  = (r_state == S_GNT1);

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master bus arbiter and master-to-slave multiplexer for the dual-core MIPS system. It is the responder side of the `breq_`/`bgrt_` handshake that each core drives. It grants the shared bus to one core at a time using round-robin, and routes the granted core's address, write data and memwrite onto the shared slave bus toward the devices/SRAM block.

## Interface
Parameters:
- `WIDTH`, 32: address and data width.
- `MAX_HOLD`, 16: maximum grant length in cycles when preemption is compiled in. Must be ≥2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_`  in  1  synchronous, active-low reset (`Enable_` = 0).
- `breq0_`  in  1  master 0 bus request, active-low.
- `breq1_`  in  1  master 1 bus request, active-low.
- `bgrt0_`  out  1  master 0 bus grant, active-low, registered.
- `bgrt1_`  out  1  master 1 bus grant, active-low, registered.
- `m0_adr`, `m1_adr`  in  WIDTH  master byte addresses.
- `m0_wdata`, `m1_wdata`  in  WIDTH  master write data.
- `m0_memwrite`, `m1_memwrite`  in  1  master write strobes, active-high.
- `s_adr`  out  WIDTH  shared bus address.
- `s_wdata`  out  WIDTH  shared bus write data.
- `s_memwrite`  out  1  shared bus write strobe, active-high.
- `busy`  out  1  high while either grant is asserted.
- `owner`  out  1  index of the granted master. Meaningful only when `busy`=1; reads 0 otherwise.

## Operation
- FSM states: IDLE, GNT0, GNT1. Grants are decoded from registered state: GNT0 → `bgrt0_`=0, GNT1 → `bgrt1_`=0, otherwise both are 1. The two grants are never low in the same cycle.
- `last` register: index of the most recently granted master. Reset value is 1, so master 0 wins the first contention.
- IDLE:
  - Only one master requesting: that master is granted.
  - Both requesting: the master ≠ `last` is granted.
  - Neither requesting: stay in IDLE.
- GNTx, `breqx_` still 0: stay in GNTx (subject to preemption, see Configuration).
- GNTx, `breqx_`=1 sampled:
  - Other master requesting: go directly to the other GNT state, with no IDLE bubble.
  - Otherwise: go to IDLE.
- `last` updates to x on every entry into GNTx.
- Mux (combinational from state):
  - GNTx: `s_adr`/`s_wdata` = `mx_adr`/`mx_wdata`; `s_memwrite` = `mx_memwrite`.
  - IDLE: `s_adr`=0, `s_wdata`=0, `s_memwrite`=0.
  - A non-granted master's memwrite never reaches `s_memwrite`.
- Reset values: state IDLE, `bgrt0_`=`bgrt1_`=1, `busy`=0, `owner`=0, `s_memwrite`=0, `s_adr`=`s_wdata`=0, `last`=1, hold counter 0.
- Reset mid-grant: takes effect at the next edge regardless of requests; grants drop and `last` returns to 1.

## Timing
- Request-to-grant latency: a request sampled low at edge n gives a grant low after edge n, i.e. 1 cycle.
- Release-to-regrant latency: release sampled at edge n removes the old grant and asserts the new grant at the same edge n.
- Mux path is combinational. A granted master's writedata/adr/memwrite appear on `s_*` in the same cycle.
- A master issues memwrite only while its `bgrt_`=0. The slave samples `s_*` on the rising edge.

## Configuration
- `BUS_ARB_PREEMPT_EN` defined:
  - A hold counter clears on every grant change and increments each cycle in GNTx.
  - When the counter equals `MAX_HOLD`-1 and the other master is requesting, the next edge moves to the other GNT state, even though `breqx_` is still 0.
  - The preempted master keeps `breqx_` low and is re-granted by round-robin later.
  - If the other master is not requesting, the counter saturates and the grant holds.
- Not defined: no counter. The owner keeps the bus until it releases `breqx_`.

## Test plan
- Reset: `reset_`=0 for 2 cycles with both requests low → both grants 1, `busy`=0, `s_memwrite`=0. Assert reset while in GNT1 → grants drop after the next edge, and the next contention goes to master 0.
- Single request: `breq0_`=0 at edge n → `bgrt0_`=0 after edge n. With `m0_adr`=20, `m0_wdata`=7, `m0_memwrite`=1 → `s_adr`=20, `s_wdata`=7, `s_memwrite`=1 in the same cycle.
- Contention from reset: both requests low → GNT0 first. Master 0 raises `breq0_` → at the next edge `bgrt0_`=1 and `bgrt1_`=0, with no IDLE cycle.
- Round-robin: after master 1 releases, both request in the same cycle → master 0 granted. Repeat → grants alternate 0,1,0,1.
- Gating: `m1_memwrite`=1, `m1_adr`=40 while `bgrt1_`=1 and master 0 owns the bus with `m0_memwrite`=0 → `s_memwrite`=0 and `s_adr` = `m0_adr`.
- Preemption (`MAX_HOLD`=4): master 0 holds its request and master 1 requests continuously.
  - Macro defined → `bgrt0_` is low for exactly 4 cycles, then `bgrt1_`=0.
  - Macro undefined → `bgrt0_` stays low for 20 cycles, until master 0 releases.
